// File: rtl/fea_step_sequencer_pkg.sv
// Shared constants, FSM encoding and index-width helper for the FEA step sequencer.
package fea_pkg;

  localparam int unsigned DATA_W_DEF    = 16;
  localparam int unsigned STEP_W_DEF    = 16;
  localparam int unsigned NUM_NODES_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_SWAP  = 3'd3,
    ST_FIN   = 3'd4
  } fea_state_t;

  // Node index width; never narrower than one bit.
  function automatic int unsigned node_idx_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned NODE_IDX_W = node_idx_w(NUM_NODES_DEF);

endpackage

// File: rtl/fea_step_sequencer_if.sv
// Operand/result bus between the sequencer and the shared node compute unit.
interface fea_step_sequencer_if #(
  parameter int unsigned DATA_W = fea_pkg::DATA_W_DEF
);

  logic              op_valid;
  logic [DATA_W-1:0] op_val;
  logic [DATA_W-1:0] op_pos;
  logic [DATA_W-1:0] op_in1;
  logic [DATA_W-1:0] op_posx1;
  logic [DATA_W-1:0] op_in2;
  logic [DATA_W-1:0] op_posx2;
  logic [DATA_W-1:0] op_kval;
  logic [DATA_W-1:0] op_dt;
  logic              res_valid;
  logic [DATA_W-1:0] res_val;
  logic [DATA_W-1:0] res_pos;

  modport master (
    output op_valid, op_val, op_pos, op_in1, op_posx1, op_in2, op_posx2, op_kval, op_dt,
    input  res_valid, res_val, res_pos
  );

  modport slave (
    input  op_valid, op_val, op_pos, op_in1, op_posx1, op_in2, op_posx2, op_kval, op_dt,
    output res_valid, res_val, res_pos
  );

endinterface

// File: rtl/fea_step_sequencer_node_bank.sv
// Double-buffered node state: current bank is read/configured, shadow bank
// collects the next step's results; swap copies boundaries and flips banks.
module fea_node_bank #(
  parameter  int unsigned NUM_NODES = 8,
  parameter  int unsigned DATA_W    = 16,
  localparam int unsigned IDX_W     = $clog2(NUM_NODES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic              rd_ahead,
  output logic [DATA_W-1:0] lft_val,
  output logic [DATA_W-1:0] lft_pos,
  output logic [DATA_W-1:0] mid_val,
  output logic [DATA_W-1:0] mid_pos,
  output logic [DATA_W-1:0] rgt_val,
  output logic [DATA_W-1:0] rgt_pos,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_val,
  input  logic [DATA_W-1:0] wr_pos,
  input  logic              swap,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_addr,
  input  logic [DATA_W-1:0] cfg_val,
  input  logic [DATA_W-1:0] cfg_pos,
  output logic [DATA_W-1:0] rd_val,
  output logic [DATA_W-1:0] rd_pos
);

  logic              sel;
  logic [DATA_W-1:0] val_q [2][NUM_NODES];
  logic [DATA_W-1:0] pos_q [2][NUM_NODES];
  logic [IDX_W-1:0]  nb_addr_c [3];
  logic [DATA_W-1:0] nb_val_c  [3];
  logic [DATA_W-1:0] nb_pos_c  [3];
  logic              cfg_in_range_c;

  assign cfg_in_range_c = (32'(cfg_addr) < NUM_NODES);

  // Neighbour read addresses around the node about to be issued.
  always_comb begin
    nb_addr_c[0] = rd_idx - IDX_W'(1);
    nb_addr_c[1] = rd_idx;
    nb_addr_c[2] = rd_idx + IDX_W'(1);
  end

  // Neighbour reads; with rd_ahead, interior nodes come from the bank that
  // becomes current at this edge (boundaries are identical in both after swap).
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      nb_val_c[k] = '0;
      nb_pos_c[k] = '0;
      if (32'(nb_addr_c[k]) < NUM_NODES) begin
        if (rd_ahead && (nb_addr_c[k] != '0) && (32'(nb_addr_c[k]) != NUM_NODES - 1)) begin
          nb_val_c[k] = val_q[~sel][nb_addr_c[k]];
          nb_pos_c[k] = pos_q[~sel][nb_addr_c[k]];
        end else begin
          nb_val_c[k] = val_q[sel][nb_addr_c[k]];
          nb_pos_c[k] = pos_q[sel][nb_addr_c[k]];
        end
      end
    end
  end

  assign lft_val = nb_val_c[0];
  assign lft_pos = nb_pos_c[0];
  assign mid_val = nb_val_c[1];
  assign mid_pos = nb_pos_c[1];
  assign rgt_val = nb_val_c[2];
  assign rgt_pos = nb_pos_c[2];

  // Host read port on the current bank; out-of-range addresses read zero.
  assign rd_val = cfg_in_range_c ? val_q[sel][cfg_addr] : '0;
  assign rd_pos = cfg_in_range_c ? pos_q[sel][cfg_addr] : '0;

  // Bank storage: config writes to current, results to shadow, swap flips.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < NUM_NODES; i++) begin
          val_q[b][i] <= '0;
          pos_q[b][i] <= '0;
        end
      end
    end else begin
      if (cfg_we && cfg_in_range_c) begin
        val_q[sel][cfg_addr] <= cfg_val;
        pos_q[sel][cfg_addr] <= cfg_pos;
      end
      if (wr_en) begin
        val_q[~sel][wr_idx] <= wr_val;
        pos_q[~sel][wr_idx] <= wr_pos;
      end
      if (swap) begin
        val_q[~sel][0]           <= val_q[sel][0];
        pos_q[~sel][0]           <= pos_q[sel][0];
        val_q[~sel][NUM_NODES-1] <= val_q[sel][NUM_NODES-1];
        pos_q[~sel][NUM_NODES-1] <= pos_q[sel][NUM_NODES-1];
        sel                      <= ~sel;
      end
    end
  end

endmodule

// File: rtl/fea_step_sequencer.sv
// Time-step controller: sweeps the shared node unit over all interior nodes
// (Jacobi style, double-buffered) num_steps times, then pulses done.
module fea_step_sequencer
  import fea_pkg::*;
#(
  parameter  int unsigned NUM_NODES = NUM_NODES_DEF,
  parameter  int unsigned DATA_W    = DATA_W_DEF,
  parameter  int unsigned STEP_W    = STEP_W_DEF,
  localparam int unsigned IDX_W     = node_idx_w(NUM_NODES)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [STEP_W-1:0]    num_steps,
  input  logic [DATA_W-1:0]    kval,
  input  logic [DATA_W-1:0]    dt,
  output logic                 busy,
  output logic                 done,
  input  logic                 cfg_we,
  input  logic [IDX_W-1:0]     cfg_addr,
  input  logic [DATA_W-1:0]    cfg_val,
  input  logic [DATA_W-1:0]    cfg_pos,
  output logic [DATA_W-1:0]    rd_val,
  output logic [DATA_W-1:0]    rd_pos,
  fea_step_sequencer_if.master nu
);

  localparam int unsigned LAST_INT = NUM_NODES - 2;

  fea_state_t        state;
  logic [IDX_W-1:0]  idx;
  logic [STEP_W-1:0] steps_left;

  logic              issue_c;
  logic [IDX_W-1:0]  issue_idx_c;
  logic              swap_c;
  logic              res_wr_c;
  logic              cfg_we_c;
  logic              last_node_c;
  logic [DATA_W-1:0] l_val_c, l_pos_c, m_val_c, m_pos_c, r_val_c, r_pos_c;

  assign last_node_c = (32'(idx) >= LAST_INT);
  assign swap_c      = (state == ST_SWAP);
  assign res_wr_c    = (state == ST_WAIT) && nu.res_valid;
  assign cfg_we_c    = cfg_we && !busy;

  // Decide whether the next state is ISSUE, and for which node.
  always_comb begin
    issue_c     = 1'b0;
    issue_idx_c = idx;
    case (state)
      ST_IDLE: begin
        if (start && (num_steps != '0)) begin
          issue_c     = 1'b1;
          issue_idx_c = IDX_W'(1);
        end
      end
      ST_WAIT: begin
        if (nu.res_valid && !last_node_c) begin
          issue_c     = 1'b1;
          issue_idx_c = idx + IDX_W'(1);
        end
      end
      ST_SWAP: begin
        if (steps_left != STEP_W'(1)) begin
          issue_c     = 1'b1;
          issue_idx_c = IDX_W'(1);
        end
      end
      default: ;
    endcase
  end

  fea_node_bank #(
    .NUM_NODES (NUM_NODES),
    .DATA_W    (DATA_W)
  ) u_bank (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (issue_idx_c),
    .rd_ahead (swap_c),
    .lft_val  (l_val_c),
    .lft_pos  (l_pos_c),
    .mid_val  (m_val_c),
    .mid_pos  (m_pos_c),
    .rgt_val  (r_val_c),
    .rgt_pos  (r_pos_c),
    .wr_en    (res_wr_c),
    .wr_idx   (idx),
    .wr_val   (nu.res_val),
    .wr_pos   (nu.res_pos),
    .swap     (swap_c),
    .cfg_we   (cfg_we_c),
    .cfg_addr (cfg_addr),
    .cfg_val  (cfg_val),
    .cfg_pos  (cfg_pos),
    .rd_val   (rd_val),
    .rd_pos   (rd_pos)
  );

  // Sequencer FSM, step/node counters and registered operand outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      idx         <= '0;
      steps_left  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      nu.op_valid <= 1'b0;
      nu.op_val   <= '0;
      nu.op_pos   <= '0;
      nu.op_in1   <= '0;
      nu.op_posx1 <= '0;
      nu.op_in2   <= '0;
      nu.op_posx2 <= '0;
      nu.op_kval  <= '0;
      nu.op_dt    <= '0;
    end else begin
      nu.op_valid <= issue_c;
      done        <= 1'b0;
      if (issue_c) begin
        idx         <= issue_idx_c;
        nu.op_val   <= m_val_c;
        nu.op_pos   <= m_pos_c;
        nu.op_in1   <= l_val_c;
        nu.op_posx1 <= l_pos_c;
        nu.op_in2   <= r_val_c;
        nu.op_posx2 <= r_pos_c;
      end
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (num_steps != '0) begin
              steps_left <= num_steps;
              nu.op_kval <= kval;
              nu.op_dt   <= dt;
              busy       <= 1'b1;
              state      <= ST_ISSUE;
            end else begin
              done  <= 1'b1;
              state <= ST_FIN;
            end
          end
        end
        ST_ISSUE: state <= ST_WAIT;
        ST_WAIT: begin
          if (nu.res_valid) begin
            state <= last_node_c ? ST_SWAP : ST_ISSUE;
          end
        end
        ST_SWAP: begin
          steps_left <= steps_left - STEP_W'(1);
          if (steps_left == STEP_W'(1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_FIN;
          end else begin
            state <= ST_ISSUE;
          end
        end
        ST_FIN:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fea_step_sequencer.sv
// Bench for fea_step_sequencer: node-unit stub plus an array-level Jacobi model.
module tb_fea_step_sequencer;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned SW = 16;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [SW-1:0] num_steps;
  logic [DW-1:0] kval, dt;
  logic          busy, done;
  logic          cfg_we;
  logic [1:0]    cfg_addr;
  logic [DW-1:0] cfg_val, cfg_pos;
  logic [DW-1:0] rd_val, rd_pos;

  fea_step_sequencer_if #(.DATA_W(DW)) nu ();

  fea_step_sequencer #(
    .NUM_NODES (N),
    .DATA_W    (DW),
    .STEP_W    (SW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .num_steps (num_steps),
    .kval      (kval),
    .dt        (dt),
    .busy      (busy),
    .done      (done),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_val   (cfg_val),
    .cfg_pos   (cfg_pos),
    .rd_val    (rd_val),
    .rd_pos    (rd_pos),
    .nu        (nu)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk  = 0;
  int n_pass = 0;

  // Monitor-owned counters.
  int busy_cnt = 0;
  int done_cnt = 0;
  // Stub-owned counters.
  int op_cnt    = 0;
  int lat_sum   = 0;
  int stab_err  = 0;
  int kd_err    = 0;
  int spur_done = 0;
  // Main-owned controls.
  int            spur_req = 0;
  bit            lat_mode = 1'b0;
  logic [DW-1:0] exp_kval = '0;
  logic [DW-1:0] exp_dt   = '0;

  logic [DW-1:0] m_val [N];
  logic [DW-1:0] m_pos [N];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Node function: arithmetic mean of the two neighbours.
  function automatic logic [DW-1:0] avg(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic signed [DW:0] s;
    logic signed [DW:0] t;
    s = {a[DW-1], a} + {b[DW-1], b};
    t = s >>> 1;
    return t[DW-1:0];
  endfunction

  function automatic logic [8*DW-1:0] ops_now();
    return {nu.op_val, nu.op_pos, nu.op_in1, nu.op_posx1,
            nu.op_in2, nu.op_posx2, nu.op_kval, nu.op_dt};
  endfunction

  // Jacobi reference: each sweep recomputes interiors from the previous array.
  task automatic model_run(input int steps);
    logic [DW-1:0] nv [N];
    for (int s = 0; s < steps; s++) begin
      nv = m_val;
      for (int i = 1; i < int'(N) - 1; i++) nv[i] = avg(m_val[i-1], m_val[i+1]);
      m_val = nv;
    end
  endtask

  // Busy / done cycle monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) done_cnt++;
    end
  end

  // Node-unit stub with fixed (2) or random (1..5) latency.
  initial begin
    logic [8*DW-1:0] c_all;
    logic [DW-1:0]   c_in1, c_in2, c_pos;
    int              lat;
    bit              aborted;
    nu.res_valid = 1'b0;
    nu.res_val   = '0;
    nu.res_pos   = '0;
    forever begin
      @(negedge clk);
      while (nu.op_valid === 1'b1 && rst_n === 1'b1) begin
        c_all = ops_now();
        c_in1 = nu.op_in1;
        c_in2 = nu.op_in2;
        c_pos = nu.op_pos;
        aborted = 1'b0;
        if (nu.op_kval !== exp_kval || nu.op_dt !== exp_dt) kd_err++;
        lat = lat_mode ? int'($urandom_range(1, 5)) : 2;
        op_cnt++;
        lat_sum += lat;
        if (spur_req != spur_done) begin
          nu.res_valid = 1'b1;
          nu.res_val   = 16'h7fff;
          nu.res_pos   = 16'h7fff;
          spur_done++;
        end
        for (int k = 0; k < lat; k++) begin
          @(negedge clk);
          nu.res_valid = 1'b0;
          if (rst_n !== 1'b1) aborted = 1'b1;
          if (!aborted && (ops_now() !== c_all || nu.op_valid !== 1'b0)) stab_err++;
        end
        nu.res_val   = avg(c_in1, c_in2);
        nu.res_pos   = c_pos;
        nu.res_valid = 1'b1;
        @(negedge clk);
        nu.res_valid = 1'b0;
      end
    end
  end

  task automatic write_all();
    for (int i = 0; i < int'(N); i++) begin
      @(negedge clk);
      cfg_we   = 1'b1;
      cfg_addr = 2'(i);
      cfg_val  = m_val[i];
      cfg_pos  = m_pos[i];
    end
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic check_state(input string tag);
    for (int i = 0; i < int'(N); i++) begin
      cfg_addr = 2'(i);
      #1;
      check($sformatf("%s_val%0d", tag, i), 32'(rd_val), 32'(m_val[i]));
      check($sformatf("%s_pos%0d", tag, i), 32'(rd_pos), 32'(m_pos[i]));
    end
  endtask

  task automatic rand_load();
    for (int i = 0; i < int'(N); i++) begin
      m_val[i] = 16'($urandom);
      m_pos[i] = 16'($urandom);
    end
    write_all();
  endtask

  task automatic run(input int steps, input bit interfere, output int busy_d, output int op_d);
    int b0, d0, o0, l0, s0, k0, cyc;
    bit seen;
    b0 = busy_cnt; d0 = done_cnt; o0 = op_cnt; l0 = lat_sum; s0 = stab_err; k0 = kd_err;
    exp_kval = 16'($urandom);
    exp_dt   = 16'($urandom);
    @(negedge clk);
    start = 1'b1; num_steps = SW'(steps); kval = exp_kval; dt = exp_dt;
    @(negedge clk);
    start = 1'b0; kval = ~exp_kval; dt = ~exp_dt;
    seen = (done === 1'b1);
    if (steps == 0) check("zero_done_next_cycle", 32'(done), 1);
    cyc = 0;
    while (!seen && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (interfere && cyc == 4) begin
        start = 1'b1; num_steps = 5;
        cfg_we = 1'b1; cfg_addr = 2'd1; cfg_val = 99; cfg_pos = 99;
        spur_req++;
      end else begin
        start = 1'b0; cfg_we = 1'b0;
      end
      seen = (done === 1'b1);
    end
    start = 1'b0; cfg_we = 1'b0;
    if (!seen) check("done_timeout", 0, 1);
    @(negedge clk);
    @(negedge clk);
    model_run(steps);
    busy_d = busy_cnt - b0;
    op_d   = op_cnt - o0;
    check("busy_cycles", busy_d, (lat_sum - l0) + op_d + steps);
    check("op_count", op_d, steps * (int'(N) - 2));
    check("done_pulses", done_cnt - d0, 1);
    check("kval_dt_latched", kd_err - k0, 0);
    check("ops_stable", stab_err - s0, 0);
    check_state("run");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bd, od, o0, d0, cyc;
    logic [8*DW-1:0] o;
    rst_n = 1'b0; start = 1'b0; num_steps = '0; kval = '0; dt = '0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_val = '0; cfg_pos = '0;
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_op_valid", 32'(nu.op_valid), 0);
    o = ops_now();
    check("rst_ops_nonzero", 32'(o != '0), 0);
    for (int i = 0; i < int'(N); i++) begin m_val[i] = '0; m_pos[i] = '0; end
    check_state("rst");
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Directed single step, L=2.
    lat_mode = 1'b0;
    m_val = '{16'd0, 16'd0, 16'd0, 16'd40};
    m_pos = '{16'd0, 16'd1, 16'd2, 16'd3};
    write_all();
    run(1, 1'b0, bd, od);
    check("t1_busy7", bd, 7);
    cfg_addr = 2'd2; #1;
    check("t1_node2_20", 32'(rd_val), 20);

    // Directed two steps.
    m_val = '{16'd0, 16'd0, 16'd0, 16'd40};
    write_all();
    run(2, 1'b0, bd, od);
    check("t2_busy14", bd, 14);
    check("t2_ops4", od, 4);
    cfg_addr = 2'd1; #1;
    check("t2_node1_10", 32'(rd_val), 10);

    // Zero steps: immediate done, nothing changes.
    run(0, 1'b0, bd, od);
    check("t0_busy0", bd, 0);
    check("t0_ops0", od, 0);

    // Mid-run start, cfg write and spurious result are all ignored.
    m_val = '{16'd0, 16'd0, 16'd0, 16'd40};
    write_all();
    run(2, 1'b1, bd, od);
    check("ti_busy14", bd, 14);
    cfg_addr = 2'd1; #1;
    check("ti_node1_10", 32'(rd_val), 10);

    // Random data, random latency, random step counts.
    lat_mode = 1'b1;
    for (int r = 0; r < 4; r++) begin
      rand_load();
      run(int'($urandom_range(1, 4)), 1'b0, bd, od);
    end

    // Reset during the second sweep.
    lat_mode = 1'b0;
    rand_load();
    o0 = op_cnt; d0 = done_cnt;
    @(negedge clk);
    start = 1'b1; num_steps = 3; exp_kval = 16'($urandom); kval = exp_kval;
    exp_dt = 16'($urandom); dt = exp_dt;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (op_cnt - o0 < 3 && cyc < 200) begin @(negedge clk); cyc++; end
    if (op_cnt - o0 < 3) check("rst_wait_timeout", 0, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_op_valid", 32'(nu.op_valid), 0);
    for (int i = 0; i < int'(N); i++) begin m_val[i] = '0; m_pos[i] = '0; end
    check_state("midrst");
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("midrst_no_done", done_cnt - d0, 0);
    check("midrst_busy_after", 32'(busy), 0);

    // Fresh run after reset.
    lat_mode = 1'b1;
    rand_load();
    run(2, 1'b0, bd, od);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
